reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
Parametrised successor to the single-port-write, two-read architectural register file, targeting the pipelined RISC-V datapath.
- Adds a clocked write port with synchronous reset.
- Adds a per-register busy scoreboard so decode can detect RAW hazards against in-flight producers.
- Adds an outstanding-producer counter.
- Sits between decode (rs1/rs2 lookup, rd reservation) and writeback.

Parameters:
XLEN, 64, data width of each register
NREG, 32, number of registers; register 0 is hardwired zero
AW, 5, register index width; must satisfy 2**AW >= NREG

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
rs1  input  AW  read index, port 1
rs2  input  AW  read index, port 2
readdata1  output  XLEN  register[rs1]
readdata2  output  XLEN  register[rs2]
rs1_busy  output  1  register[rs1] has an outstanding producer
rs2_busy  output  1  register[rs2] has an outstanding producer
hazard  output  1  rs1_busy | rs2_busy
issue_valid  input  1  reserve issue_rd as destination of a newly issued instruction
issue_rd  input  AW  destination being reserved
writereg  input  1  writeback enable
rd  input  AW  writeback index
writedata  input  XLEN  writeback data
pending_cnt  output  AW+1  number of registers currently busy

Behaviour:
- Single clock clk; reset is synchronous and active-high.
- Reset (sampled high at posedge clk):
  - all NREG registers = 0; all busy bits = 0; pending_cnt = 0.
  - reset overrides any same-cycle write or issue.
  - reset mid-operation discards all reservations.
- Reads: combinational, zero latency.
  - readdata1/2 reflect register contents after the most recent edge.
  - index 0 always reads 0, busy 0.
  - index >= NREG reads 0, busy 0.
- Write: at posedge, if writereg && rd != 0 && rd < NREG, register[rd] <= writedata.
  - Visible on readdata from the following cycle (bypass option below excepted).
  - Writes to index 0 or out of range are ignored.
- Scoreboard, evaluated at each posedge (no reset):
  - set condition S: issue_valid && issue_rd != 0 && issue_rd < NREG.
  - clear condition C: writereg && rd valid (nonzero, < NREG) && busy[rd].
  - S and C on different registers: both apply.
  - S and C on the same register: set wins; register stays busy (new producer); write data is still committed.
  - writeback to a non-busy register: data written, busy unchanged.
  - issue to an already-busy register: stays busy.
- pending_cnt:
  - +1 when S targets a non-busy register.
  - -1 when C clears a register that does not remain busy.
  - net 0 when both happen in the same cycle.
  - never wraps; the range 0..NREG-1 is guaranteed by construction.
- hazard: purely combinational from rs1_busy/rs2_busy.

Optional Feature:
REGFILE_BYPASS_EN
- Defined, when writereg && rd valid in the current cycle:
  - rs1 == rd: readdata1 = writedata combinationally, and rs1_busy = 0 unless the set-wins case applies (issue_valid && issue_rd == rd).
  - rs2 == rd: same rule for readdata2 / rs2_busy.
  - Index 0 is never bypassed.
- Undefined: no forwarding. Reads return the pre-edge value, and busy stays asserted until the edge that clears it.

Test Plan:
1. Reset, then read rs1=5, rs2=31 -> readdata1=0, readdata2=0, busy=0, pending_cnt=0, hazard=0.
2. Write rd=3, data 0xDEAD_BEEF_0000_0001; next cycle rs1=3 -> readdata1=0xDEAD_BEEF_0000_0001. Write rd=0, data 0xFF -> rs2=0 reads 0.
3. Issue rd=7 -> next cycle rs1=7: rs1_busy=1, hazard=1, pending_cnt=1. Writeback rd=7, data 0x42 -> next cycle busy=0, pending_cnt=0, readdata1=0x42.
4. rd=9 busy; same cycle: issue_rd=9 and writeback rd=9, data 0x11 -> busy[9] stays 1, pending_cnt unchanged, register[9]=0x11.
5. Same cycle: issue_rd=4 and writeback of busy rd=6 -> busy[4]=1, busy[6]=0, pending_cnt unchanged. Then reset asserted mid-stream -> all busy 0, pending_cnt=0, registers 0.
6. With REGFILE_BYPASS_EN: rd=10 busy; writeback rd=10, data 0x55 while rs2=10 -> readdata2=0x55 and rs2_busy=0 in the same cycle. Without the macro: readdata2 = old value, rs2_busy=1 until the edge.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: architectural register file with busy scoreboard.
//   Two combinational read ports (rs1/rs2) return data and busy flags.
//   One clocked write port (writereg/rd/writedata) commits at posedge.
//   Issue port (issue_valid/issue_rd) reserves a destination as busy.
//   pending_cnt counts busy registers. Register 0 reads zero and is never busy.
//   Indices >= NREG read zero, are never busy, and are ignored on write/issue.
//   reset is synchronous and active-high; it clears data, busy bits and the count.
// Optional build macro: REGFILE_BYPASS_EN forwards same-cycle writeback data
//   and busy clearing onto the read ports.
module reg_file_sb #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] readdata1,
  output logic [XLEN-1:0] readdata2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            hazard,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            writereg,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] writedata,
  output logic [AW:0]     pending_cnt
);

  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;

  // Index is writable/trackable: nonzero and inside the array.
  function automatic logic idx_ok(input logic [AW-1:0] i);
    return (i != '0) && ({1'b0, i} < NREG_W);
  endfunction

  logic set_ok, wr_ok, clr_ok, same_rd, cnt_inc, cnt_dec;

  // Scoreboard update qualifiers.
  always_comb begin
    set_ok  = issue_valid && idx_ok(issue_rd);
    wr_ok   = writereg && idx_ok(rd);
    clr_ok  = wr_ok && busy[rd];
    same_rd = set_ok && (issue_rd == rd);
    // A set on an already-busy register adds no producer; a clear that is
    // overridden by a same-cycle set on the same register removes none.
    cnt_inc = set_ok && !busy[issue_rd];
    cnt_dec = clr_ok && !same_rd;
  end

  // Register array, busy bits and outstanding-producer count.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      if (wr_ok) regs[rd] <= writedata;
      // Clear first, then set, so a same-register set wins.
      if (clr_ok) busy[rd] <= 1'b0;
      if (set_ok) busy[issue_rd] <= 1'b1;
      pending_cnt <= pending_cnt + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
    end
  end

  logic [XLEN-1:0] arr1, arr2;
  logic            bsy1, bsy2;

  // Raw array lookups, masked for index 0 and out-of-range indices.
  always_comb begin
    arr1 = '0;
    arr2 = '0;
    bsy1 = 1'b0;
    bsy2 = 1'b0;
    if (idx_ok(rs1)) begin
      arr1 = regs[rs1];
      bsy1 = busy[rs1];
    end
    if (idx_ok(rs2)) begin
      arr2 = regs[rs2];
      bsy2 = busy[rs2];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp1, byp2;

  // Forward writeback; busy drops unless a same-cycle issue re-reserves rd.
  always_comb begin
    byp1      = wr_ok && (rs1 == rd);
    byp2      = wr_ok && (rs2 == rd);
    readdata1 = byp1 ? writedata : arr1;
    readdata2 = byp2 ? writedata : arr2;
    rs1_busy  = bsy1 && !(byp1 && !same_rd);
    rs2_busy  = bsy2 && !(byp2 && !same_rd);
  end
`else
  // No forwarding: pre-edge contents and busy state.
  always_comb begin
    readdata1 = arr1;
    readdata2 = arr2;
    rs1_busy  = bsy1;
    rs2_busy  = bsy2;
  end
`endif

  assign hazard = rs1_busy | rs2_busy;

endmodule
